// File: rtl/mem_map_pkg.sv
// Memory map shared by the bus arbiter and its region decoder:
// region bases, one-hot slave selects, FSM states and default wait states.
package mem_map_pkg;

  localparam logic [15:0] REGION_FLASH  = 16'h0000;
  localparam logic [15:0] REGION_BRAM   = 16'h0001;
  localparam logic [15:0] REGION_SRAM   = 16'h0002;
  localparam logic [15:0] REGION_PERIPH = 16'h0003;

  localparam logic [3:0] MEM_SEL_NONE   = 4'b0000;
  localparam logic [3:0] MEM_SEL_FLASH  = 4'b0001;
  localparam logic [3:0] MEM_SEL_BRAM   = 4'b0010;
  localparam logic [3:0] MEM_SEL_SRAM   = 4'b0100;
  localparam logic [3:0] MEM_SEL_PERIPH = 4'b1000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERROR  = 2'd2
  } state_e;

  localparam int WS_FLASH_DEF  = 3;
  localparam int WS_BRAM_DEF   = 0;
  localparam int WS_SRAM_DEF   = 1;
  localparam int WS_PERIPH_DEF = 2;

endpackage

// File: rtl/mem_region_decode.sv
// Maps the upper address half-word onto a one-hot slave select;
// anything above the peripheral region is flagged invalid.
module mem_region_decode
  import mem_map_pkg::*;
(
  input  logic [15:0] addr_hi_i,
  output logic [3:0]  sel_o,
  output logic        invalid_o
);

  always_comb begin
    sel_o     = MEM_SEL_NONE;
    invalid_o = 1'b0;
    case (addr_hi_i)
      REGION_FLASH:  sel_o = MEM_SEL_FLASH;
      REGION_BRAM:   sel_o = MEM_SEL_BRAM;
      REGION_SRAM:   sel_o = MEM_SEL_SRAM;
      REGION_PERIPH: sel_o = MEM_SEL_PERIPH;
      default:       invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the shared memory bus: grants in IDLE,
// latches the request, counts region wait states and returns done/err/rdata.
module mem_bus_arbiter
  import mem_map_pkg::*;
#(
  parameter int WS_FLASH  = WS_FLASH_DEF,
  parameter int WS_BRAM   = WS_BRAM_DEF,
  parameter int WS_SRAM   = WS_SRAM_DEF,
  parameter int WS_PERIPH = WS_PERIPH_DEF,
  parameter int CNT_W     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_we,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_done,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_we,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_done,
  output logic        m1_err,
  output logic        mem_en,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [31:0]       addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              gnt;
  logic [31:0]       gnt_addr;
  logic [3:0]        dec_sel;
  logic              dec_invalid;
  logic              fin_done;
  logic              fin_err;
  logic [31:0]       fin_rdata;

  function automatic logic [CNT_W-1:0] wait_states(input logic [3:0] sel);
    case (sel)
      MEM_SEL_FLASH:  return CNT_W'(WS_FLASH);
      MEM_SEL_BRAM:   return CNT_W'(WS_BRAM);
      MEM_SEL_SRAM:   return CNT_W'(WS_SRAM);
      MEM_SEL_PERIPH: return CNT_W'(WS_PERIPH);
      default:        return '0;
    endcase
  endfunction

  // On contention the master that did not win last time is granted.
  always_comb begin
    if (m0_req && m1_req) gnt = ~last_grant_q;
    else                  gnt = m1_req;
    gnt_addr = gnt ? m1_addr : m0_addr;
  end

  mem_region_decode u_decode (
    .addr_hi_i (gnt_addr[31:16]),
    .sel_o     (dec_sel),
    .invalid_o (dec_invalid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      sel_q        <= MEM_SEL_NONE;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          owner_d      = gnt;
          last_grant_d = gnt;
          addr_d       = gnt_addr;
          we_d         = gnt ? m1_we : m0_we;
          wdata_d      = gnt ? m1_wdata : m0_wdata;
          if (dec_invalid) begin
            sel_d   = MEM_SEL_NONE;
            state_d = ERROR;
          end else begin
            sel_d   = dec_sel;
            cnt_d   = wait_states(dec_sel);
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs come only from the latches and are zeroed outside ACCESS.
  always_comb begin
    mem_en    = 1'b0;
    mem_sel   = MEM_SEL_NONE;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    fin_done  = 1'b0;
    fin_err   = 1'b0;
    fin_rdata = '0;
    case (state_q)
      ACCESS: begin
        mem_en    = 1'b1;
        mem_sel   = sel_q;
        mem_addr  = addr_q;
        mem_we    = we_q;
        mem_wdata = wdata_q;
        if (cnt_q == '0) begin
          fin_done  = 1'b1;
          fin_rdata = we_q ? 32'h0 : mem_rdata;
        end
      end
      ERROR: begin
        fin_done = 1'b1;
        fin_err  = 1'b1;
      end
      default: ;
    endcase
    m0_done  = fin_done && !owner_q;
    m0_err   = fin_err  && !owner_q;
    m0_rdata = owner_q ? 32'h0 : fin_rdata;
    m1_done  = fin_done && owner_q;
    m1_err   = fin_err  && owner_q;
    m1_rdata = owner_q ? fin_rdata : 32'h0;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: BRAM read, contention, decode error,
// SRAM write with input churn, reset mid-access and round-robin fairness.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_done, m0_err, m1_done, m1_err;
  logic        mem_en, mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_addr   (m0_addr),
    .m0_we     (m0_we),
    .m0_wdata  (m0_wdata),
    .m0_rdata  (m0_rdata),
    .m0_done   (m0_done),
    .m0_err    (m0_err),
    .m1_req    (m1_req),
    .m1_addr   (m1_addr),
    .m1_we     (m1_we),
    .m1_wdata  (m1_wdata),
    .m1_rdata  (m1_rdata),
    .m1_done   (m1_done),
    .m1_err    (m1_err),
    .mem_en    (mem_en),
    .mem_sel   (mem_sel),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_en"},  32'(mem_en),  32'h0);
    chk({tag, "_sel"}, 32'(mem_sel), 32'h0);
    chk({tag, "_d0"},  32'(m0_done), 32'h0);
    chk({tag, "_d1"},  32'(m1_done), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    mem_rdata = '0;
    cyc();
    cyc();
    chk_idle("rst");
    chk("rst_addr",  mem_addr,  32'h0);
    chk("rst_we",    32'(mem_we), 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_err0",  32'(m0_err), 32'h0);
    chk("rst_err1",  32'(m1_err), 32'h0);
    rst = 1'b0;
    cyc();

    // BRAM read by m1, zero wait states
    m1_req = 1'b1; m1_addr = 32'h0001_0040; m1_we = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    cyc();
    chk("bram_en",    32'(mem_en),  32'h1);
    chk("bram_sel",   32'(mem_sel), 32'h2);
    chk("bram_addr",  mem_addr,     32'h0001_0040);
    chk("bram_done1", 32'(m1_done), 32'h1);
    chk("bram_rd1",   m1_rdata,     32'hDEAD_BEEF);
    chk("bram_err1",  32'(m1_err),  32'h0);
    chk("bram_done0", 32'(m0_done), 32'h0);
    chk("bram_rd0",   m0_rdata,     32'h0);
    chk("bram_err0",  32'(m0_err),  32'h0);
    m1_req = 1'b0;
    cyc();
    chk_idle("bram_after");

    // Contention right after reset: m0 flash (4 cycles) then m1 SRAM (2 cycles)
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h0000_0100; m0_we = 1'b0;
    m1_req = 1'b1; m1_addr = 32'h0002_0000; m1_we = 1'b0;
    mem_rdata = 32'h1111_2222;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("cont_m0_en",   32'(mem_en),  32'h1);
      chk("cont_m0_sel",  32'(mem_sel), 32'h1);
      chk("cont_m0_addr", mem_addr,     32'h0000_0100);
      chk("cont_m0_done", 32'(m0_done), (i == 3) ? 32'h1 : 32'h0);
      chk("cont_m1_wait", 32'(m1_done), 32'h0);
    end
    chk("cont_m0_rd", m0_rdata, 32'h1111_2222);
    chk("cont_m1_rd", m1_rdata, 32'h0);
    m0_req = 1'b0;
    cyc();
    chk_idle("cont_gap");
    cyc();
    chk("cont_m1_en1",   32'(mem_en),  32'h1);
    chk("cont_m1_sel",   32'(mem_sel), 32'h4);
    chk("cont_m1_addr",  mem_addr,     32'h0002_0000);
    chk("cont_m1_done1", 32'(m1_done), 32'h0);
    cyc();
    chk("cont_m1_en2",   32'(mem_en),  32'h1);
    chk("cont_m1_done2", 32'(m1_done), 32'h1);
    chk("cont_m1_rd2",   m1_rdata,     32'h1111_2222);
    chk("cont_m0_quiet", 32'(m0_done), 32'h0);
    m1_req = 1'b0;
    cyc();
    chk_idle("cont_after");

    // Decode error on m0
    m0_req = 1'b1; m0_addr = 32'h0004_0000; m0_we = 1'b0;
    cyc();
    chk("derr_done0", 32'(m0_done), 32'h1);
    chk("derr_err0",  32'(m0_err),  32'h1);
    chk("derr_en",    32'(mem_en),  32'h0);
    chk("derr_sel",   32'(mem_sel), 32'h0);
    chk("derr_done1", 32'(m1_done), 32'h0);
    chk("derr_err1",  32'(m1_err),  32'h0);
    m0_req = 1'b0;
    cyc();
    chk_idle("derr_after");
    chk("derr_err_clr", 32'(m0_err), 32'h0);

    // SRAM write by m1; master inputs churn mid-access
    m1_req = 1'b1; m1_addr = 32'h0002_0008; m1_we = 1'b1; m1_wdata = 32'h1234_5678;
    mem_rdata = 32'hCAFE_F00D;
    cyc();
    chk("wr_we1",   32'(mem_we),  32'h1);
    chk("wr_wd1",   mem_wdata,    32'h1234_5678);
    chk("wr_sel1",  32'(mem_sel), 32'h4);
    chk("wr_done1", 32'(m1_done), 32'h0);
    m1_addr = 32'h0003_FFFC; m1_we = 1'b0; m1_wdata = 32'hFFFF_FFFF;
    cyc();
    chk("wr_we2",   32'(mem_we),  32'h1);
    chk("wr_wd2",   mem_wdata,    32'h1234_5678);
    chk("wr_sel2",  32'(mem_sel), 32'h4);
    chk("wr_addr2", mem_addr,     32'h0002_0008);
    chk("wr_done2", 32'(m1_done), 32'h1);
    chk("wr_rd",    m1_rdata,     32'h0);
    m1_req = 1'b0;
    cyc();
    chk_idle("wr_after");

    // Reset in the 2nd cycle of a flash access aborts it
    m0_req = 1'b1; m0_addr = 32'h0000_0200; m0_we = 1'b0;
    cyc();
    chk("rma_en1", 32'(mem_en), 32'h1);
    cyc();
    chk("rma_en2", 32'(mem_en), 32'h1);
    rst = 1'b1;
    cyc();
    chk_idle("rma_abort");
    rst = 1'b0;

    // Fairness after reset: both hold req to BRAM; grants alternate m0 first
    m0_req = 1'b1; m0_addr = 32'h0001_0000;
    m1_req = 1'b1; m1_addr = 32'h0001_0100; m1_we = 1'b0;
    mem_rdata = 32'h5A5A_0001;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("fair_en",    32'(mem_en),  32'h1);
      chk("fair_d0",    32'(m0_done), (i % 2 == 0) ? 32'h1 : 32'h0);
      chk("fair_d1",    32'(m1_done), (i % 2 == 1) ? 32'h1 : 32'h0);
      chk("fair_addr",  mem_addr,     (i % 2 == 0) ? 32'h0001_0000 : 32'h0001_0100);
      cyc();
      chk_idle("fair_gap");
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    cyc();
    chk_idle("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
